hp_event_scheduler: RTL

Sequences every change to the player HP register and shares its single update path between N_REQ hit, poison and heal requesters. It uses round-robin arbitration, applies an invulnerability cooldown after each damage hit, and detects death. It sits between the bullet/collision logic and the health bar/HP text renderer, and replaces ad-hoc per-tick HP decrementing. Stage ROM loads the starting HP via load_hp.

---
 rtl/hp_event_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hp_event_scheduler.sv
// hp_event_scheduler
//   Owns the player HP register and serialises every change to it. N_REQ
//   hit/poison/heal requesters share one update path through round-robin
//   arbitration. A damage hit arms an invulnerability cooldown paced by tick_i,
//   and reaching zero HP can park the block in a DEAD state until the stage
//   ROM reloads HP.
//
// Ports
//   clk_i             system clock
//   reset_i           asynchronous active-high reset
//   tick_i            centi-second enable pulse, paces the cooldown
//   req_i             per-requester request, held until granted
//   req_amount_i      amount for requester k in [k*AMT_WIDTH +: AMT_WIDTH]
//   req_is_heal_i     per-requester type: 1 = heal, 0 = damage
//   grant_o           one-hot, one-cycle acceptance pulse
//   load_hp_i         load HP from the stage ROM (highest priority)
//   load_value_i      HP value to load
//   hp_max_i          saturation ceiling for heals and loads
//   sensitivity_i     cooldown length in ticks after a damage hit
//   reset_when_dead_i enables the DEAD state
//   hp_current_o      registered HP
//   is_player_dead_o  registered death flag
//   invuln_active_o   cooldown counter is nonzero
//   busy_o            high while applying an update or dead
module hp_event_scheduler #(
  parameter int N_REQ     = 4,
  parameter int HP_WIDTH  = 10,
  parameter int AMT_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tick_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*AMT_WIDTH-1:0] req_amount_i,
  input  logic [N_REQ-1:0]           req_is_heal_i,
  output logic [N_REQ-1:0]           grant_o,
  input  logic                       load_hp_i,
  input  logic [HP_WIDTH-1:0]        load_value_i,
  input  logic [HP_WIDTH-1:0]        hp_max_i,
  input  logic [6:0]                 sensitivity_i,
  input  logic                       reset_when_dead_i,
  output logic [HP_WIDTH-1:0]        hp_current_o,
  output logic                       is_player_dead_o,
  output logic                       invuln_active_o,
  output logic                       busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, DEAD} state_t;

  state_t                 state_q, state_d;
  logic [HP_WIDTH-1:0]    hp_q, hp_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic                   dead_q, dead_d;
  logic [6:0]             cd_q, cd_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [AMT_WIDTH-1:0]   amt_q, amt_d;
  logic                   heal_q, heal_d;

  // Per-requester eligibility and amount slices.
  logic [N_REQ-1:0]       elig;
  logic [AMT_WIDTH-1:0]   amt_arr [N_REQ];
  logic                   cd_zero;

  assign cd_zero = (cd_q == 7'd0);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    // Heals bypass the cooldown; damage waits for it to expire.
    assign elig[gi]    = req_i[gi] & (req_is_heal_i[gi] | cd_zero);
    assign amt_arr[gi] = req_amount_i[gi*AMT_WIDTH +: AMT_WIDTH];
  end

  // Round-robin search starting at rr_q, wrapping at N_REQ.
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!found && elig[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  // Arithmetic is one bit wider than HP so neither heal nor damage wraps.
  logic [HP_WIDTH:0]   hp_ext, amt_ext, heal_sum, dmg_diff;
  logic [HP_WIDTH-1:0] heal_res, dmg_res, load_res;

  assign hp_ext   = {1'b0, hp_q};
  assign amt_ext  = {{(HP_WIDTH+1-AMT_WIDTH){1'b0}}, amt_q};
  assign heal_sum = hp_ext + amt_ext;
  assign dmg_diff = hp_ext - amt_ext;
  assign heal_res = (heal_sum > {1'b0, hp_max_i}) ? hp_max_i : heal_sum[HP_WIDTH-1:0];
  assign dmg_res  = (hp_ext > amt_ext) ? dmg_diff[HP_WIDTH-1:0] : '0;
  assign load_res = (load_value_i < hp_max_i) ? load_value_i : hp_max_i;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    grant_d = '0;
    dead_d  = dead_q;
    rr_d    = rr_q;
    amt_d   = amt_q;
    heal_d  = heal_q;
    cd_d    = (tick_i && !cd_zero) ? cd_q - 7'd1 : cd_q;

    if (load_hp_i) begin
      // Load wins over everything, including an operation already in APPLY.
      hp_d    = load_res;
      cd_d    = 7'd0;
      dead_d  = 1'b0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_d[pick] = 1'b1;
            amt_d         = amt_arr[pick];
            heal_d        = req_is_heal_i[pick];
            rr_d          = (pick == IDX_W'(N_REQ-1)) ? '0 : pick + IDX_W'(1);
            state_d       = APPLY;
          end
        end
        APPLY: begin
          state_d = IDLE;
          if (heal_q) begin
            hp_d = heal_res;
          end else begin
            // A zero-amount hit leaves HP and the cooldown alone; a reload
            // takes precedence over a tick in the same cycle.
            if (amt_q != '0) begin
              hp_d = dmg_res;
              cd_d = sensitivity_i;
            end
            if (dmg_res == '0 && reset_when_dead_i) begin
              state_d = DEAD;
              dead_d  = 1'b1;
            end
          end
        end
        DEAD: begin
          state_d = DEAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      hp_q    <= '1;
      grant_q <= '0;
      dead_q  <= 1'b0;
      cd_q    <= 7'd0;
      rr_q    <= '0;
      amt_q   <= '0;
      heal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      grant_q <= grant_d;
      dead_q  <= dead_d;
      cd_q    <= cd_d;
      rr_q    <= rr_d;
      amt_q   <= amt_d;
      heal_q  <= heal_d;
    end
  end

  assign grant_o          = grant_q;
  assign hp_current_o     = hp_q;
  assign is_player_dead_o = dead_q;
  assign invuln_active_o  = !cd_zero;
  assign busy_o           = (state_q != IDLE);

endmodule
